// File: rtl/vco_tune_if.sv
// System-control side of the VCO tuning controller: run request, target and results.
interface vco_tune_if #(
  parameter int unsigned CODE_W   = 8,
  parameter int unsigned WIN_LOG2 = 8
);
  logic                start;
  logic [WIN_LOG2:0]   target;
  logic                busy;
  logic                done;
  logic [CODE_W-1:0]   code;
  logic [WIN_LOG2:0]   meas;

  // System controller: requests runs, observes status and results.
  modport master (
    output start, target,
    input  busy, done, code, meas
  );

  // Tuning controller: accepts runs, reports status and results.
  modport slave (
    input  start, target,
    output busy, done, code, meas
  );
endinterface

// File: rtl/vco_tune_ctrl.sv
// Successive-approximation VCO tuner: binary-searches the largest control code
// whose per-window count of v_out MSB rising edges does not exceed the target.
module vco_tune_ctrl #(
  parameter int unsigned CODE_W   = 8,
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned SETTLE   = 16
) (
  input  logic              clk,
  input  logic              rst,
  vco_tune_if.slave         ctl,
  input  logic [CODE_W-1:0] v_out,
  output logic [CODE_W-1:0] v_in
);

  localparam int unsigned CNT_W = WIN_LOG2 + 1;
  localparam int unsigned IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_MEASURE = 3'd2;
  localparam logic [2:0] S_DECIDE  = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  logic [2:0]          state_q,    state_d;
  logic [CODE_W-1:0]   trial_q,    trial_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [CNT_W-1:0]    tgt_q,      tgt_d;
  logic [SET_W-1:0]    set_cnt_q,  set_cnt_d;
  logic [WIN_LOG2-1:0] win_cnt_q,  win_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                prev_q,     prev_d;
  logic [CODE_W-1:0]   v_in_q,     v_in_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [CODE_W-1:0]   code_q,     code_d;
  logic [CNT_W-1:0]    meas_q,     meas_d;

  logic                vbit;
  logic                keep;
  logic [CODE_W-1:0]   bit_mask;
  logic [CODE_W-1:0]   trial_nxt;
  logic [CNT_W-1:0]    edge_nxt;
  logic                unused_v_out;

  // Only the VCO output MSB carries the oscillation we count.
  assign vbit         = v_out[CODE_W-1];
  assign unused_v_out = ^v_out[CODE_W-2:0];

  assign v_in     = v_in_q;
  assign ctl.busy = busy_q;
  assign ctl.done = done_q;
  assign ctl.code = code_q;
  assign ctl.meas = meas_q;

  // State and datapath registers; reset aborts any run and clears all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      trial_q    <= '0;
      idx_q      <= '0;
      tgt_q      <= '0;
      set_cnt_q  <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      prev_q     <= 1'b0;
      v_in_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      code_q     <= '0;
      meas_q     <= '0;
    end else begin
      state_q    <= state_d;
      trial_q    <= trial_d;
      idx_q      <= idx_d;
      tgt_q      <= tgt_d;
      set_cnt_q  <= set_cnt_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      prev_q     <= prev_d;
      v_in_q     <= v_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      code_q     <= code_d;
      meas_q     <= meas_d;
    end
  end

  // Next-state and datapath: settle, count one window, then keep or drop the trial bit.
  always_comb begin
    state_d    = state_q;
    trial_d    = trial_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    set_cnt_d  = set_cnt_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    prev_d     = prev_q;
    v_in_d     = v_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    code_d     = code_q;
    meas_d     = meas_q;
    keep       = (meas_q <= tgt_q);
    bit_mask   = CODE_W'(1) << idx_q;
    trial_nxt  = keep ? trial_q : (trial_q & ~bit_mask);
    edge_nxt   = edge_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          tgt_d     = ctl.target;
          trial_d   = CODE_W'(1) << (CODE_W - 1);
          idx_d     = IDX_W'(CODE_W - 1);
          v_in_d    = CODE_W'(1) << (CODE_W - 1);
          set_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE - 1)) begin
          // Seed the edge detector with the live level so entry is never an edge.
          prev_d     = vbit;
          edge_cnt_d = '0;
          win_cnt_d  = '0;
          state_d    = S_MEASURE;
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end

      S_MEASURE: begin
        if (vbit && !prev_q && (edge_cnt_q != {CNT_W{1'b1}})) begin
          edge_nxt = edge_cnt_q + CNT_W'(1);
        end
        edge_cnt_d = edge_nxt;
        prev_d     = vbit;
        win_cnt_d  = win_cnt_q + WIN_LOG2'(1);
        if (win_cnt_q == {WIN_LOG2{1'b1}}) begin
          meas_d  = edge_nxt;
          state_d = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (idx_q == '0) begin
          trial_d = trial_nxt;
          code_d  = trial_nxt;
          v_in_d  = trial_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          trial_d   = trial_nxt | (bit_mask >> 1);
          v_in_d    = trial_nxt | (bit_mask >> 1);
          idx_d     = idx_q - IDX_W'(1);
          set_cnt_d = '0;
          state_d   = S_SETTLE;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vco_tune_ctrl.sv
// Bench for vco_tune_ctrl: phase-accumulator VCO model, table of tuning runs,
// plus hand-written sequences for start-while-busy, mid-run reset and back-to-back runs.
module tb_vco_tune_ctrl;

  localparam int unsigned CODE_W   = 8;
  localparam int unsigned WIN_LOG2 = 8;
  localparam int unsigned SETTLE   = 16;
  localparam int          STEP     = 273;   // 16 settle + 256 window + 1 decide
  localparam int          LAT      = 2185;  // 8 steps + finish cycle

  typedef struct {
    logic [8:0] target;
    bit         dead;
    logic [7:0] exp_code;
    logic [8:0] exp_meas;   // count from the last window, i.e. trial with bit 0 set
    bit         chk_seq;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] v_in;
  logic [7:0] v_out;
  logic [7:0] vco_acc = 8'h00;
  logic       dead = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[5];

  always #5 clk = ~clk;

  vco_tune_if #(.CODE_W(CODE_W), .WIN_LOG2(WIN_LOG2)) ctl ();

  vco_tune_ctrl #(.CODE_W(CODE_W), .WIN_LOG2(WIN_LOG2), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .ctl   (ctl),
    .v_out (v_out),
    .v_in  (v_in)
  );

  // VCO model: phase accumulator; dead mode parks the MSB high to expose false entry edges.
  always_ff @(posedge clk) vco_acc <= vco_acc + v_in;
  assign v_out = dead ? 8'h80 : vco_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One tuning run from the start sample edge through the idle cycle after done.
  task automatic run(input logic [8:0] tgt, input bit dd, input logic [7:0] ecode,
                     input logic [8:0] emeas, input bit seq, input int pulse_at, input bit hold);
    int cyc;
    bit got;
    dead       = dd;
    ctl.target = tgt;
    ctl.start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) ctl.start = 1'b0;
    cyc = 1;
    got = 1'b0;
    chk("busy_rise", 32'(ctl.busy), 1);
    while (!got && cyc < 2400) begin
      if (ctl.done) begin
        got = 1'b1;
      end else begin
        if (seq && cyc == 1)        chk("trial_seq0", 32'(v_in), 128);
        if (seq && cyc == STEP + 1) chk("trial_seq1", 32'(v_in), 64);
        if (seq && cyc == 2*STEP+1) chk("trial_seq2", 32'(v_in), 96);
        if (dd && (cyc % STEP) == 0) chk("dead_meas", 32'(ctl.meas), 0);
        if (pulse_at > 0 && cyc == pulse_at) begin
          ctl.start  = 1'b1;
          ctl.target = 9'd20;
        end
        if (pulse_at > 0 && cyc == pulse_at + 1) begin
          ctl.start  = 1'b0;
          ctl.target = tgt;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("done_latency", 32'(cyc), 32'(LAT));
    chk("final_code", 32'(ctl.code), 32'(ecode));
    chk("final_v_in", 32'(v_in), 32'(ecode));
    chk("final_meas", 32'(ctl.meas), 32'(emeas));
    chk("busy_in_finish", 32'(ctl.busy), 0);
    @(posedge clk); #1;
    chk("done_width", 32'(ctl.done), 0);
    chk("idle_not_busy", 32'(ctl.busy), 0);
    chk("v_in_held", 32'(v_in), 32'(ecode));
  endtask

  initial begin
    vecs[0] = '{target: 9'd100, dead: 1'b0, exp_code: 8'd100, exp_meas: 9'd101, chk_seq: 1'b0};
    vecs[1] = '{target: 9'd0,   dead: 1'b0, exp_code: 8'd0,   exp_meas: 9'd1,   chk_seq: 1'b0};
    vecs[2] = '{target: 9'd127, dead: 1'b0, exp_code: 8'd127, exp_meas: 9'd127, chk_seq: 1'b1};
    vecs[3] = '{target: 9'd511, dead: 1'b0, exp_code: 8'd255, exp_meas: 9'd1,   chk_seq: 1'b0};
    vecs[4] = '{target: 9'd0,   dead: 1'b1, exp_code: 8'd255, exp_meas: 9'd0,   chk_seq: 1'b0};

    ctl.start  = 1'b0;
    ctl.target = '0;

    // Power-on reset: outputs must clear without a clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_v_in", 32'(v_in), 0);
    chk("rst_busy", 32'(ctl.busy), 0);
    chk("rst_done", 32'(ctl.done), 0);
    chk("rst_code", 32'(ctl.code), 0);
    chk("rst_meas", 32'(ctl.meas), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].target, vecs[i].dead, vecs[i].exp_code, vecs[i].exp_meas,
          vecs[i].chk_seq, 0, 1'b0);
    end

    // Start pulsed mid-run with a different target must be ignored.
    run(9'd100, 1'b0, 8'd100, 9'd101, 1'b0, 500, 1'b0);

    // Reset during the bit-4 window aborts the run asynchronously.
    ctl.target = 9'd100;
    ctl.start  = 1'b1;
    @(posedge clk); #1;
    ctl.start = 1'b0;
    repeat (899) @(posedge clk);
    #3;
    chk("pre_reset_busy", 32'(ctl.busy), 1);
    rst = 1'b0;
    #1;
    chk("abort_v_in", 32'(v_in), 0);
    chk("abort_busy", 32'(ctl.busy), 0);
    chk("abort_done", 32'(ctl.done), 0);
    chk("abort_code", 32'(ctl.code), 0);
    chk("abort_meas", 32'(ctl.meas), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(ctl.done), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 32'(ctl.busy), 0);
    run(9'd50, 1'b0, 8'd50, 9'd51, 1'b0, 0, 1'b0);

    // Back-to-back runs with start held high through the first completion.
    run(9'd30, 1'b0, 8'd30, 9'd31, 1'b0, 0, 1'b1);
    run(9'd90, 1'b0, 8'd90, 9'd91, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
